// File: rtl/magnetron_ctrl_pkg.sv
// Shared encodings and defaults for the magnetron latch driver.
package magnetron_ctrl_pkg;

   localparam int TIME_W_DEF      = 7;
   localparam int ACK_TIMEOUT_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START_REQ = 3'd1,
      ST_COOKING   = 3'd2,
      ST_STOP_REQ  = 3'd3,
      ST_PAUSED    = 3'd4,
      ST_FAULT     = 3'd5
   } state_e;

   function automatic logic is_busy(input state_e s);
      return (s == ST_START_REQ) || (s == ST_COOKING) || (s == ST_STOP_REQ);
   endfunction

endpackage

// File: rtl/magnetron_ctrl_edge_det.sv
// Rising-edge detector; the first cycle after reset only arms it, so a level
// already high at reset release is not reported as an edge.
module magnetron_ctrl_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic q;
   logic armed;

   always_ff @(posedge clk) begin
      if (rst) begin
         q     <= 1'b0;
         armed <= 1'b0;
      end else begin
         q     <= d;
         armed <= 1'b1;
      end
   end

   assign rise = armed & d & ~q;

endmodule

// File: rtl/magnetron_ctrl.sv
// Magnetron SR-latch driver: one-clk set/reset commands, cook-time countdown,
// door pause and latch-acknowledge fault detection.
module magnetron_ctrl
   import magnetron_ctrl_pkg::*;
#(
   parameter int TIME_W      = TIME_W_DEF,
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_1hz,
   input  logic [TIME_W-1:0] time_in,
   input  logic              load,
   input  logic              start,
   input  logic              stop,
   input  logic              door_closed,
   input  logic              mag_q,
   output logic              mag_set,
   output logic              mag_reset,
   output logic [TIME_W-1:0] time_left,
   output logic              busy,
   output logic              done,
   output logic              fault,
   output state_e            state_dbg
);

   localparam int                 ACK_W    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [ACK_W-1:0]   ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

   state_e            state, state_n;
   logic [TIME_W-1:0] time_n;
   logic [ACK_W-1:0]  ack_cnt, ack_n;
   logic              pause_pend, pause_n;
   logic              clr_pend, clr_n;
   logic              fault_n, set_n, reset_n, done_n;
   logic              start_edge, stop_edge;

   magnetron_ctrl_edge_det u_start_det (.clk(clk), .rst(rst), .d(start), .rise(start_edge));
   magnetron_ctrl_edge_det u_stop_det  (.clk(clk), .rst(rst), .d(stop),  .rise(stop_edge));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         time_left  <= '0;
         ack_cnt    <= '0;
         pause_pend <= 1'b0;
         clr_pend   <= 1'b0;
         fault      <= 1'b0;
         mag_set    <= 1'b0;
         mag_reset  <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         time_left  <= time_n;
         ack_cnt    <= ack_n;
         pause_pend <= pause_n;
         clr_pend   <= clr_n;
         fault      <= fault_n;
         mag_set    <= set_n;
         mag_reset  <= reset_n;
         done       <= done_n;
      end
   end

   // set_n/reset_n are only raised on distinct branches, so 11 never reaches the latch.
   always_comb begin
      state_n = state;
      time_n  = time_left;
      ack_n   = ack_cnt;
      pause_n = pause_pend;
      clr_n   = clr_pend;
      fault_n = fault;
      set_n   = 1'b0;
      reset_n = 1'b0;
      done_n  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (stop)      time_n = '0;
            else if (load) time_n = time_in;
            if (start_edge && door_closed && (time_left != '0)) begin
               state_n = ST_START_REQ;
               set_n   = 1'b1;
               ack_n   = '0;
               pause_n = 1'b0;
            end
         end
         ST_START_REQ: begin
            if (!door_closed) begin
               state_n = ST_STOP_REQ;
               reset_n = 1'b1;
               pause_n = 1'b1;
               clr_n   = 1'b0;
               ack_n   = '0;
            end else if (mag_q) begin
               state_n = ST_COOKING;
               ack_n   = '0;
            end else if (ack_cnt == ACK_LAST) begin
               state_n = ST_FAULT;
               reset_n = 1'b1;
               fault_n = 1'b1;
               ack_n   = '0;
            end else begin
               ack_n = ack_cnt + 1'b1;
            end
         end
         ST_COOKING: begin
            if (!door_closed) begin
               state_n = ST_STOP_REQ;
               reset_n = 1'b1;
               pause_n = 1'b1;
               clr_n   = 1'b0;
               ack_n   = '0;
            end else if (stop_edge) begin
               state_n = ST_STOP_REQ;
               reset_n = 1'b1;
               pause_n = 1'b0;
               clr_n   = 1'b1;
               ack_n   = '0;
            end else if (!mag_q) begin
               state_n = ST_FAULT;
               fault_n = 1'b1;
               ack_n   = '0;
            end else if (tick_1hz && (time_left != '0)) begin
               time_n = time_left - TIME_W'(1);
               if (time_left == TIME_W'(1)) begin
                  done_n  = 1'b1;
                  state_n = ST_STOP_REQ;
                  reset_n = 1'b1;
                  pause_n = 1'b0;
                  clr_n   = 1'b0;
                  ack_n   = '0;
               end
            end
         end
         ST_STOP_REQ: begin
            if (!mag_q) begin
               state_n = pause_pend ? ST_PAUSED : ST_IDLE;
               if (clr_pend) time_n = '0;
               clr_n   = 1'b0;
               ack_n   = '0;
            end else if (ack_cnt == ACK_LAST) begin
               state_n = ST_FAULT;
               fault_n = 1'b1;
               ack_n   = '0;
            end else begin
               ack_n = ack_cnt + 1'b1;
            end
         end
         ST_PAUSED: begin
            if (stop_edge) begin
               state_n = ST_IDLE;
               time_n  = '0;
               pause_n = 1'b0;
            end else if (start_edge && door_closed) begin
               state_n = ST_START_REQ;
               set_n   = 1'b1;
               ack_n   = '0;
               pause_n = 1'b0;
            end
         end
         ST_FAULT: begin
            // Keep nudging a stuck-on latch off; only rst leaves this state.
            if (mag_q) begin
               if (ack_cnt == ACK_LAST) begin
                  reset_n = 1'b1;
                  ack_n   = '0;
               end else begin
                  ack_n = ack_cnt + 1'b1;
               end
            end else begin
               ack_n = '0;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign busy      = is_busy(state);
   assign state_dbg = state;

endmodule

// File: tb/tb_magnetron_ctrl.sv
// Directed cycle-by-cycle bench for magnetron_ctrl with a behavioural SR latch.
module tb_magnetron_ctrl;
   import magnetron_ctrl_pkg::*;

   localparam logic [2:0] S_IDLE = 3'd0, S_SREQ = 3'd1, S_COOK = 3'd2,
                          S_PREQ = 3'd3, S_PAUS = 3'd4, S_FLT  = 3'd5;

   typedef struct packed {
      logic       set;
      logic       rp;
      logic [6:0] tl;
      logic       busy;
      logic       done;
      logic       fault;
      logic [2:0] st;
   } outs_t;

   typedef struct {
      logic       rst;
      logic       load;
      logic [6:0] tin;
      logic       start;
      logic       stop;
      logic       door;
      logic       tick;
      outs_t      exp;
   } vec_t;

   logic       clk, rst, tick_1hz, load, start, stop, door_closed, mag_q;
   logic [6:0] time_in, time_left;
   logic       mag_set, mag_reset, busy, done, fault;
   state_e     state_dbg;
   logic       ignore_set, stuck_lo;
   int         n_vec, n_err;
   vec_t       tab[11];

   magnetron_ctrl dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .time_in(time_in), .load(load),
      .start(start), .stop(stop), .door_closed(door_closed), .mag_q(mag_q),
      .mag_set(mag_set), .mag_reset(mag_reset), .time_left(time_left), .busy(busy),
      .done(done), .fault(fault), .state_dbg(state_dbg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Latch model: Q follows a set/reset pulse one clock later.
   always @(posedge clk) begin
      if (rst || stuck_lo)              mag_q <= 1'b0;
      else if (mag_reset)               mag_q <= 1'b0;
      else if (mag_set && !ignore_set)  mag_q <= 1'b1;
   end

   always @(negedge clk) begin
      if (mag_set && mag_reset) begin
         n_err++;
         $display("FAIL set_reset_overlap: mag_set=%b mag_reset=%b, required never both 1", mag_set, mag_reset);
      end
   end

   function automatic vec_t mk(input logic r, input logic ld, input logic [6:0] tin,
                               input logic s, input logic p, input logic d, input logic t,
                               input logic es, input logic er, input logic [6:0] etl,
                               input logic eb, input logic ed, input logic ef, input logic [2:0] est);
      vec_t v;
      v.rst = r; v.load = ld; v.tin = tin; v.start = s; v.stop = p; v.door = d; v.tick = t;
      v.exp = '{set: es, rp: er, tl: etl, busy: eb, done: ed, fault: ef, st: est};
      return v;
   endfunction

   task automatic apply(input vec_t v, input string name);
      outs_t got;
      rst = v.rst; load = v.load; time_in = v.tin; start = v.start;
      stop = v.stop; door_closed = v.door; tick_1hz = v.tick;
      @(posedge clk);
      #1;
      got = {mag_set, mag_reset, time_left, busy, done, fault, state_dbg};
      n_vec++;
      if (got !== v.exp) begin
         n_err++;
         $display("FAIL %s: got set=%b rst=%b tl=%0d busy=%b done=%b fault=%b st=%0d, want set=%b rst=%b tl=%0d busy=%b done=%b fault=%b st=%0d",
                  name, got.set, got.rp, got.tl, got.busy, got.done, got.fault, got.st,
                  v.exp.set, v.exp.rp, v.exp.tl, v.exp.busy, v.exp.done, v.exp.fault, v.exp.st);
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      ignore_set = 1'b0; stuck_lo = 1'b0; mag_q = 1'b0;
      rst = 1'b1; load = 1'b0; time_in = '0; start = 1'b0; stop = 1'b0;
      door_closed = 1'b1; tick_1hz = 1'b0;

      //           rst ld tin s p d t   set rp tl b dn f st
      tab[0]  = mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, S_IDLE);
      tab[1]  = mk(0, 1, 3, 0, 0, 1, 0,  0, 0, 3, 0, 0, 0, S_IDLE);
      tab[2]  = mk(0, 0, 0, 1, 0, 1, 0,  1, 0, 3, 1, 0, 0, S_SREQ);
      tab[3]  = mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 3, 1, 0, 0, S_SREQ);
      tab[4]  = mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 3, 1, 0, 0, S_COOK);
      tab[5]  = mk(0, 0, 0, 0, 0, 1, 1,  0, 0, 2, 1, 0, 0, S_COOK);
      tab[6]  = mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 2, 1, 0, 0, S_COOK);
      tab[7]  = mk(0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 1, 0, 0, S_COOK);
      tab[8]  = mk(0, 0, 0, 0, 0, 1, 1,  0, 1, 0, 1, 1, 0, S_PREQ);
      tab[9]  = mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0, 0, S_PREQ);
      tab[10] = mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, S_IDLE);

      apply(mk(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, S_IDLE), "reset_0");
      apply(mk(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, S_IDLE), "reset_1");

      // Nominal cook of 3 seconds.
      for (int i = 0; i < 11; i++) apply(tab[i], $sformatf("nominal_%0d", i));

      // Door opens mid-cook, ticks while paused, resume, then stop.
      apply(mk(0, 1, 5, 0, 0, 1, 0,  0, 0, 5, 0, 0, 0, S_IDLE), "door_load");
      apply(mk(0, 0, 0, 1, 0, 1, 0,  1, 0, 5, 1, 0, 0, S_SREQ), "door_start");
      apply(mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 5, 1, 0, 0, S_SREQ), "door_ack_wait");
      apply(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 5, 1, 0, 0, S_COOK), "door_cook");
      apply(mk(0, 0, 0, 0, 0, 1, 1,  0, 0, 4, 1, 0, 0, S_COOK), "door_tick1");
      apply(mk(0, 0, 0, 0, 0, 1, 1,  0, 0, 3, 1, 0, 0, S_COOK), "door_tick2");
      apply(mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 3, 1, 0, 0, S_PREQ), "door_open");
      apply(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 3, 1, 0, 0, S_PREQ), "door_ack_off");
      apply(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 3, 0, 0, 0, S_PAUS), "door_paused");
      apply(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 3, 0, 0, 0, S_PAUS), "paused_tick");
      apply(mk(0, 1, 9, 0, 0, 1, 1,  0, 0, 3, 0, 0, 0, S_PAUS), "paused_load");
      apply(mk(0, 0, 0, 1, 0, 1, 0,  1, 0, 3, 1, 0, 0, S_SREQ), "resume_start");
      apply(mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 3, 1, 0, 0, S_SREQ), "resume_ack");
      apply(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 3, 1, 0, 0, S_COOK), "resume_cook");
      apply(mk(0, 0, 0, 0, 0, 1, 1,  0, 0, 2, 1, 0, 0, S_COOK), "resume_tick");
      apply(mk(0, 0, 0, 0, 1, 1, 0,  0, 1, 2, 1, 0, 0, S_PREQ), "cook_stop");
      apply(mk(0, 0, 0, 0, 1, 1, 0,  0, 0, 2, 1, 0, 0, S_PREQ), "cook_stop_wait");
      apply(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, S_IDLE), "cook_stop_clear");

      // Tick, stop and door-open in the same cycle at time_left=4.
      apply(mk(0, 1, 4, 0, 0, 1, 0,  0, 0, 4, 0, 0, 0, S_IDLE), "coin_load");
      apply(mk(0, 0, 0, 1, 0, 1, 0,  1, 0, 4, 1, 0, 0, S_SREQ), "coin_start");
      apply(mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 4, 1, 0, 0, S_SREQ), "coin_ack");
      apply(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 4, 1, 0, 0, S_COOK), "coin_cook");
      apply(mk(0, 0, 0, 0, 1, 0, 1,  0, 1, 4, 1, 0, 0, S_PREQ), "coin_all");
      apply(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 4, 1, 0, 0, S_PREQ), "coin_wait");
      apply(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 4, 0, 0, 0, S_PAUS), "coin_paused");
      apply(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, S_IDLE), "paused_stop");

      // Start guards.
      apply(mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, S_IDLE), "guard_zero_time");
      apply(mk(0, 1, 5, 0, 0, 1, 0,  0, 0, 5, 0, 0, 0, S_IDLE), "guard_load");
      apply(mk(0, 0, 0, 1, 0, 0, 0,  0, 0, 5, 0, 0, 0, S_IDLE), "guard_door_open");
      apply(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 5, 0, 0, 0, S_IDLE), "guard_idle");

      // Reset while cooking.
      apply(mk(0, 0, 0, 1, 0, 1, 0,  1, 0, 5, 1, 0, 0, S_SREQ), "rstc_start");
      apply(mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 5, 1, 0, 0, S_SREQ), "rstc_ack");
      apply(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 5, 1, 0, 0, S_COOK), "rstc_cook");
      apply(mk(0, 0, 0, 0, 0, 1, 1,  0, 0, 4, 1, 0, 0, S_COOK), "rstc_tick");
      apply(mk(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, S_IDLE), "rstc_reset");
      apply(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, S_IDLE), "rstc_after");

      // Latch never acknowledges the set.
      ignore_set = 1'b1;
      apply(mk(0, 1, 2, 0, 0, 1, 0,  0, 0, 2, 0, 0, 0, S_IDLE), "tmo_load");
      apply(mk(0, 0, 0, 1, 0, 1, 0,  1, 0, 2, 1, 0, 0, S_SREQ), "tmo_start");
      apply(mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 2, 1, 0, 0, S_SREQ), "tmo_wait1");
      apply(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 2, 1, 0, 0, S_SREQ), "tmo_wait2");
      apply(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 2, 1, 0, 0, S_SREQ), "tmo_wait3");
      apply(mk(0, 0, 0, 0, 0, 1, 0,  0, 1, 2, 0, 0, 1, S_FLT),  "tmo_fault");
      apply(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 2, 0, 0, 1, S_FLT),  "tmo_hold");
      apply(mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 2, 0, 0, 1, S_FLT),  "tmo_start_ign");
      apply(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 2, 0, 0, 1, S_FLT),  "tmo_hold2");
      apply(mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 2, 0, 0, 1, S_FLT),  "tmo_start_ign2");
      apply(mk(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, S_IDLE), "tmo_reset");
      ignore_set = 1'b0;
      apply(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, S_IDLE), "tmo_after");

      // Latch drops out unexpectedly while cooking.
      apply(mk(0, 1, 3, 0, 0, 1, 0,  0, 0, 3, 0, 0, 0, S_IDLE), "drop_load");
      apply(mk(0, 0, 0, 1, 0, 1, 0,  1, 0, 3, 1, 0, 0, S_SREQ), "drop_start");
      apply(mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 3, 1, 0, 0, S_SREQ), "drop_ack");
      apply(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 3, 1, 0, 0, S_COOK), "drop_cook");
      stuck_lo = 1'b1;
      apply(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 3, 1, 0, 0, S_COOK), "drop_edge");
      apply(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 3, 0, 0, 1, S_FLT),  "drop_fault");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
